// File: rtl/pipeline_run_ctrl.sv
// Run controller for a pipeline under test: reset hold, then free-run, bounded or single-step
// execution with a saturating enabled-cycle counter. All outputs are registered Moore decodes.
module pipeline_run_ctrl #(
  parameter int RST_CYCLES = 2,
  parameter int MAX_CYCLES = 10,
  parameter int CNT_W      = 32
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_start,
  input  logic [1:0]       i_mode,
  input  logic             i_step,
  input  logic             i_halt_req,
  output logic             o_core_reset,
  output logic             o_core_en,
  output logic             o_busy,
  output logic             o_done,
  output logic [CNT_W-1:0] o_cycle_count,
  output logic [2:0]       o_state
);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_RST_HOLD  = 3'd1,
    S_RUN       = 3'd2,
    S_STEP_WAIT = 3'd3,
    S_STEP_EXEC = 3'd4,
    S_DONE      = 3'd5
  } state_t;

  localparam int               RC_W    = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;
  localparam logic [RC_W-1:0]  RC_LOAD = RC_W'(RST_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] BUDGET  = CNT_W'(MAX_CYCLES);
  localparam logic [1:0]       M_BOUND = 2'b01;
  localparam logic [1:0]       M_STEP  = 2'b10;

  state_t           r_state;
  logic [1:0]       r_mode;
  logic [RC_W-1:0]  r_rst_cnt;
  logic [CNT_W-1:0] r_cycle_count;
  logic             r_core_reset;
  logic             r_core_en;
  logic             r_busy;
  logic             r_done;

  state_t           w_next_state;
  logic             w_en;
  logic             w_accept_start;
  logic [CNT_W-1:0] w_cnt_inc;
  logic             w_budget_hit;

  assign w_en           = (r_state == S_RUN) || (r_state == S_STEP_EXEC);
  assign w_accept_start = i_start && ((r_state == S_IDLE) || (r_state == S_DONE));
  assign w_cnt_inc      = (r_cycle_count == CNT_MAX) ? r_cycle_count : r_cycle_count + CNT_W'(1);
  // Budget is judged on the value the counter takes on this edge.
  assign w_budget_hit   = (w_cnt_inc >= BUDGET);

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE: begin
        if (i_start) w_next_state = S_RST_HOLD;
      end
      S_RST_HOLD: begin
        if (i_halt_req)          w_next_state = S_IDLE;
        else if (r_rst_cnt == '0) w_next_state = (r_mode == M_STEP) ? S_STEP_WAIT : S_RUN;
      end
      S_RUN: begin
        if (i_halt_req)                             w_next_state = S_DONE;
        else if ((r_mode == M_BOUND) && w_budget_hit) w_next_state = S_DONE;
      end
      S_STEP_WAIT: begin
        if (i_halt_req)  w_next_state = S_DONE;
        else if (i_step) w_next_state = S_STEP_EXEC;
      end
      S_STEP_EXEC: begin
        if (i_halt_req || w_budget_hit) w_next_state = S_DONE;
        else                            w_next_state = S_STEP_WAIT;
      end
      S_DONE: begin
        if (i_start) w_next_state = S_RST_HOLD;
      end
      default: w_next_state = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state       <= S_IDLE;
      r_mode        <= 2'b00;
      r_rst_cnt     <= '0;
      r_cycle_count <= '0;
      r_core_reset  <= 1'b1;
      r_core_en     <= 1'b0;
      r_busy        <= 1'b0;
      r_done        <= 1'b0;
    end else begin
      r_state      <= w_next_state;
      r_core_reset <= (w_next_state == S_IDLE) || (w_next_state == S_RST_HOLD);
      r_core_en    <= (w_next_state == S_RUN) || (w_next_state == S_STEP_EXEC);
      r_busy       <= (w_next_state == S_RST_HOLD) || (w_next_state == S_RUN) ||
                      (w_next_state == S_STEP_WAIT) || (w_next_state == S_STEP_EXEC);
      r_done       <= (w_next_state == S_DONE);
      if (w_accept_start) begin
        r_mode        <= i_mode;
        r_rst_cnt     <= RC_LOAD;
        r_cycle_count <= '0;
      end else begin
        if ((r_state == S_RST_HOLD) && (r_rst_cnt != '0)) r_rst_cnt <= r_rst_cnt - RC_W'(1);
        if (w_en) r_cycle_count <= w_cnt_inc;
      end
    end
  end

  assign o_core_reset  = r_core_reset;
  assign o_core_en     = r_core_en;
  assign o_busy        = r_busy;
  assign o_done        = r_done;
  assign o_cycle_count = r_cycle_count;
  assign o_state       = r_state;

endmodule

// File: tb/tb_pipeline_run_ctrl.sv
// Directed bench for pipeline_run_ctrl: default instance plus a 4-bit counter instance for saturation.
module tb_pipeline_run_ctrl;

  logic        clk;
  logic        i_reset, i_start, i_step, i_halt_req;
  logic [1:0]  i_mode;
  logic        o_core_reset, o_core_en, o_busy, o_done;
  logic [31:0] o_cycle_count;
  logic [2:0]  o_state;

  logic        s_reset, s_start, s_step, s_halt_req;
  logic [1:0]  s_mode;
  logic        s_core_reset, s_core_en, s_busy, s_done;
  logic [3:0]  s_cycle_count;
  logic [2:0]  s_state;

  int checks;
  int failures;
  int en_cycles;

  pipeline_run_ctrl dut (
    .i_clk(clk), .i_reset(i_reset), .i_start(i_start), .i_mode(i_mode), .i_step(i_step),
    .i_halt_req(i_halt_req), .o_core_reset(o_core_reset), .o_core_en(o_core_en),
    .o_busy(o_busy), .o_done(o_done), .o_cycle_count(o_cycle_count), .o_state(o_state)
  );

  pipeline_run_ctrl #(.RST_CYCLES(2), .MAX_CYCLES(10), .CNT_W(4)) dut_sat (
    .i_clk(clk), .i_reset(s_reset), .i_start(s_start), .i_mode(s_mode), .i_step(s_step),
    .i_halt_req(s_halt_req), .o_core_reset(s_core_reset), .o_core_en(s_core_en),
    .o_busy(s_busy), .o_done(s_done), .o_cycle_count(s_cycle_count), .o_state(s_state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Counts consecutive core_en cycles starting at RUN entry, bounded by a cycle budget.
  task automatic count_run(output int n);
    n = 0;
    for (int k = 0; k < 40; k++) begin
      if (!o_core_en) break;
      n++;
      tick();
    end
  endtask

  initial begin
    checks = 0; failures = 0;
    i_reset = 1'b1; i_start = 1'b0; i_mode = 2'b00; i_step = 1'b0; i_halt_req = 1'b0;
    s_reset = 1'b1; s_start = 1'b0; s_mode = 2'b00; s_step = 1'b0; s_halt_req = 1'b0;
    i_start = 1'b1; i_halt_req = 1'b1;
    tick(); tick();
    chk("rst_state", o_state, 0);
    chk("rst_core_reset", o_core_reset, 1);
    chk("rst_core_en", o_core_en, 0);
    chk("rst_busy", o_busy, 0);
    chk("rst_done", o_done, 0);
    chk("rst_count", o_cycle_count, 0);
    i_reset = 1'b0; s_reset = 1'b0; i_start = 1'b0;
    tick();
    chk("post_rst_state", o_state, 0);
    chk("post_rst_core_reset", o_core_reset, 1);
    tick();
    chk("idle_halt_ignored", o_state, 0);
    i_halt_req = 1'b0;

    // Bounded run
    i_mode = 2'b01; i_start = 1'b1;
    tick();
    i_start = 1'b0; i_mode = 2'b10;
    chk("bnd_hold1_state", o_state, 1);
    chk("bnd_hold1_core_reset", o_core_reset, 1);
    chk("bnd_hold1_busy", o_busy, 1);
    tick();
    chk("bnd_hold2_state", o_state, 1);
    chk("bnd_hold2_core_reset", o_core_reset, 1);
    tick();
    chk("bnd_run_state", o_state, 2);
    chk("bnd_run_core_reset", o_core_reset, 0);
    chk("bnd_run_count0", o_cycle_count, 0);
    count_run(en_cycles);
    chk("bnd_en_cycles", en_cycles, 10);
    chk("bnd_done", o_done, 1);
    chk("bnd_state_done", o_state, 5);
    chk("bnd_count", o_cycle_count, 10);
    chk("bnd_busy", o_busy, 0);
    tick();
    chk("bnd_count_held", o_cycle_count, 10);

    // Restart from DONE with start and halt together
    i_mode = 2'b01; i_start = 1'b1; i_halt_req = 1'b1;
    tick();
    i_start = 1'b0; i_halt_req = 1'b0;
    chk("rs_state", o_state, 1);
    chk("rs_count_cleared", o_cycle_count, 0);
    tick(); tick();
    chk("rs_run_state", o_state, 2);
    count_run(en_cycles);
    chk("rs_en_cycles", en_cycles, 10);
    chk("rs_done", o_done, 1);
    chk("rs_count", o_cycle_count, 10);

    // Free-run with a start attempt mid-run, then halt
    i_mode = 2'b00; i_start = 1'b1;
    tick();
    i_start = 1'b0;
    tick(); tick();
    chk("fr_run_state", o_state, 2);
    for (int k = 0; k < 10; k++) tick();
    chk("fr_count10", o_cycle_count, 10);
    i_start = 1'b1; i_mode = 2'b10;
    tick();
    i_start = 1'b0;
    chk("fr_start_ignored_state", o_state, 2);
    chk("fr_start_ignored_count", o_cycle_count, 11);
    for (int k = 0; k < 13; k++) tick();
    chk("fr_count24", o_cycle_count, 24);
    i_halt_req = 1'b1;
    tick();
    i_halt_req = 1'b0;
    chk("fr_halt_state", o_state, 5);
    chk("fr_halt_count", o_cycle_count, 25);
    chk("fr_halt_core_en", o_core_en, 0);
    tick(); tick();
    chk("fr_after_core_en", o_core_en, 0);
    chk("fr_after_count", o_cycle_count, 25);

    // Single-step
    i_mode = 2'b10; i_start = 1'b1;
    tick();
    i_start = 1'b0;
    tick(); tick();
    chk("st_wait_state", o_state, 3);
    chk("st_wait_core_en", o_core_en, 0);
    tick();
    chk("st_wait_stays", o_state, 3);
    for (int p = 1; p <= 3; p++) begin
      i_step = 1'b1;
      tick();
      i_step = 1'b0;
      chk("st_exec_core_en", o_core_en, 1);
      chk("st_exec_state", o_state, 4);
      tick();
      chk("st_back_state", o_state, 3);
      chk("st_back_count", o_cycle_count, p);
      tick();
    end
    en_cycles = 0;
    i_step = 1'b1;
    for (int k = 0; k < 20; k++) begin
      tick();
      if (o_core_en) en_cycles++;
      if (o_state == 3'd5) break;
    end
    i_step = 1'b0;
    chk("st_held_en_cycles", en_cycles, 7);
    chk("st_held_done", o_done, 1);
    chk("st_held_count", o_cycle_count, 10);

    // Halt during reset hold
    i_mode = 2'b01; i_start = 1'b1;
    tick();
    i_start = 1'b0; i_halt_req = 1'b1;
    tick();
    i_halt_req = 1'b0;
    chk("ab_hold_state", o_state, 0);
    chk("ab_hold_core_reset", o_core_reset, 1);
    chk("ab_hold_count", o_cycle_count, 0);
    chk("ab_hold_busy", o_busy, 0);

    // Reset mid-run at count 5
    i_mode = 2'b00; i_start = 1'b1;
    tick();
    i_start = 1'b0;
    tick(); tick();
    for (int k = 0; k < 5; k++) tick();
    chk("ab_run_count5", o_cycle_count, 5);
    i_reset = 1'b1;
    tick();
    i_reset = 1'b0;
    chk("ab_rst_state", o_state, 0);
    chk("ab_rst_count", o_cycle_count, 0);
    chk("ab_rst_core_en", o_core_en, 0);
    tick();
    chk("ab_rst_after_state", o_state, 0);
    chk("ab_rst_after_core_en", o_core_en, 0);

    // Saturation on the 4-bit instance
    s_mode = 2'b00; s_start = 1'b1;
    tick();
    s_start = 1'b0;
    tick(); tick();
    chk("sat_run_state", s_state, 2);
    for (int k = 0; k < 14; k++) tick();
    chk("sat_count14", s_cycle_count, 14);
    tick();
    chk("sat_count15", s_cycle_count, 15);
    for (int k = 0; k < 5; k++) tick();
    chk("sat_count_held", s_cycle_count, 15);
    chk("sat_still_run", s_state, 2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pipeline_run_ctrl.md
PIPELINE_RUN_CTRL -- requirements
Module: pipeline_run_ctrl

Interface
REQ-001 Parameter RST_CYCLES, default 2: core_reset hold length in cycles; legal range >=1.
REQ-002 Parameter MAX_CYCLES, default 10: enabled-cycle budget in bounded and step modes; legal range >=1.
REQ-003 Parameter CNT_W, default 32: cycle_count width; MAX_CYCLES SHALL be < 2^CNT_W.
REQ-004 clk  input  1  single clock; all state changes on rising edge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 start  input  1  begin a run; sampled only in IDLE or DONE.
REQ-007 mode  input  2  00 free-run, 01 bounded, 10 single-step, 11 treated as 00; sampled only with accepted start.
REQ-008 step  input  1  in single-step mode, request one enabled core cycle.
REQ-009 halt_req  input  1  stop the current run.
REQ-010 core_reset  output  1  reset driven to the pipeline under control.
REQ-011 core_en  output  1  clock enable driven to the pipeline under control.
REQ-012 busy  output  1  high in RST_HOLD, RUN, STEP_WAIT, STEP_EXEC.
REQ-013 done  output  1  high in DONE.
REQ-014 cycle_count  output  CNT_W  number of cycles core_en has been high since last accepted start.
REQ-015 state  output  3  encoded FSM state: IDLE=0, RST_HOLD=1, RUN=2, STEP_WAIT=3, STEP_EXEC=4, DONE=5.

Function
REQ-016 All outputs SHALL be Moore decodes of registered state: core_reset=1 in IDLE and RST_HOLD, else 0; core_en=1 only in RUN and STEP_EXEC.
REQ-017 IDLE: start=1 -> RST_HOLD; latch mode; clear cycle_count; load reset counter.
REQ-018 RST_HOLD SHALL last exactly RST_CYCLES cycles, then -> RUN (mode 00/01/11) or STEP_WAIT (mode 10).
REQ-019 RUN, free-run: remain until halt_req; no cycle limit.
REQ-020 RUN, bounded: core_en SHALL be high for exactly MAX_CYCLES cycles, then -> DONE.
REQ-021 STEP_WAIT: step=1 -> STEP_EXEC; step=0 -> stay.
REQ-022 STEP_EXEC SHALL last one cycle, then -> STEP_WAIT, or -> DONE if cycle_count reaches MAX_CYCLES on that edge.
REQ-023 A step held high continuously SHALL yield alternating STEP_EXEC/STEP_WAIT, one enabled cycle per two clocks.
REQ-024 cycle_count SHALL increment by 1 on every edge where core_en=1 and SHALL saturate at 2^CNT_W-1 without wrapping.
REQ-025 halt_req in RUN, STEP_WAIT or STEP_EXEC -> DONE next edge; halt_req has priority over budget expiry and step on the same edge.
REQ-026 halt_req in RST_HOLD -> IDLE; cycle_count stays 0.
REQ-027 halt_req in IDLE or DONE SHALL be ignored.
REQ-028 start while busy SHALL be ignored; mode changes outside accepted start SHALL be ignored.
REQ-029 DONE: core_reset=0, core_en=0, cycle_count held; start=1 -> RST_HOLD with cycle_count cleared on the same edge.
REQ-030 start and halt_req together in DONE: start SHALL be accepted.

Reset
REQ-031 reset=1 at a rising edge SHALL force IDLE, cycle_count=0, latched mode=00 and reset counter cleared, regardless of current state or inputs.
REQ-032 While in reset and the first cycle after it: core_reset=1, core_en=0, busy=0, done=0, state=0.
REQ-033 Reset asserted mid-run SHALL abort the run with no further core_en cycles.

Verification
REQ-034 Bounded: defaults, mode=01, start pulse -> core_reset high 2 cycles after start edge, core_en high exactly 10 consecutive cycles, then done=1, cycle_count=10.
REQ-035 Free-run with halt: mode=00, halt_req asserted 25 cycles after RUN entry -> DONE next edge, cycle_count=25, core_en=0 thereafter.
REQ-036 Single-step: mode=10, three isolated step pulses -> three one-cycle core_en pulses, cycle_count=3, state returns to 3 each time; step held high 20 cycles -> DONE when cycle_count=10.
REQ-037 Saturation: CNT_W=4, mode=00, run 20 cycles -> cycle_count stops at 15.
REQ-038 Abort paths: halt_req during RST_HOLD -> IDLE with core_reset=1, count 0; reset in RUN at count 5 -> IDLE, count 0 next cycle; start during RUN -> no effect.
REQ-039 Restart: start in DONE with mode=01 -> cycle_count cleared, second bounded run of 10 cycles completes identically.
